// File: rtl/ccff_loader_pkg.sv
// Shared types for the configuration-chain loader: FSM state encoding and the
// bit-counter width helper.
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } ccff_state_e;

   // Counter must be able to hold the full chain length itself.
   function automatic int unsigned ccff_cnt_t(input int unsigned chain_len);
      return $clog2(chain_len + 1);
   endfunction

endpackage

// File: rtl/ccff_word_buffer.sv
// One-word holding register in front of the loader's shift register.
// Accepts a word only when it is not being bypassed straight into the shifter.
module ccff_word_buffer #(
   parameter int unsigned WORD_W = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              clear,
   input  logic              enable,
   input  logic              take,
   input  logic              bypass,
   input  logic [WORD_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [WORD_W-1:0] hold,
   output logic              hold_valid
);

   assign din_ready = enable && !hold_valid;

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         hold       <= '0;
         hold_valid <= 1'b0;
      end else if (clear || take) begin
         hold_valid <= 1'b0;
      end else if (din_valid && din_ready && !bypass) begin
         hold       <= din;
         hold_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words LSB-first into a configuration chain, gating the
// chain clock per real bit, counting bits to CHAIN_LEN and folding tail parity.
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CHAIN_LEN = 1024,
   parameter int unsigned CNT_W     = ccff_cnt_t(CHAIN_LEN)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              ccff_head,
   output logic              chain_clk_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bit_cnt,
   output logic              tail_parity
);

   localparam int unsigned      REM_W   = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CHAIN_LEN);
   localparam logic [REM_W-1:0] FullRem = REM_W'(WORD_W);

   ccff_state_e       state, state_d;
   logic [WORD_W-1:0] sreg, sreg_d, hold;
   logic [REM_W-1:0]  srem, srem_d;
   logic [CNT_W-1:0]  cnt_d;
   logic              parity_d, en_d, done_d, hold_valid;
   logic              in_shift, need_load, take, bypass, accept, term, buf_clear;

   assign in_shift  = (state == StShift);
   // sreg needs a new word when empty or when its last bit leaves this cycle.
   assign need_load = in_shift &&
                      ((srem == '0) || ((srem == REM_W'(1)) && chain_clk_en));
   assign take      = need_load && hold_valid;
   assign bypass    = need_load && !hold_valid;
   assign accept    = din_valid && din_ready;
   assign term      = in_shift && chain_clk_en && (bit_cnt == LastCnt - CNT_W'(1));
   assign buf_clear = (start && !in_shift) || term;
   assign ccff_head = sreg[0];

   ccff_word_buffer #(
      .WORD_W(WORD_W)
   ) u_buf (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .clear     (buf_clear),
      .enable    (in_shift),
      .take      (take),
      .bypass    (bypass),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .hold      (hold),
      .hold_valid(hold_valid)
   );

   always_comb begin
      state_d  = state;
      sreg_d   = sreg;
      srem_d   = srem;
      cnt_d    = bit_cnt;
      parity_d = tail_parity;
      done_d   = done;
      unique case (state)
         StIdle, StDone: begin
            if (start) begin
               state_d  = StShift;
               sreg_d   = '0;
               srem_d   = '0;
               cnt_d    = '0;
               parity_d = 1'b0;
               done_d   = 1'b0;
            end
         end
         StShift: begin
            if (chain_clk_en) begin
               sreg_d   = sreg >> 1;
               srem_d   = srem - REM_W'(1);
               cnt_d    = bit_cnt + CNT_W'(1);
               parity_d = tail_parity ^ ccff_tail;
            end
            if (take) begin
               sreg_d = hold;
               srem_d = FullRem;
            end else if (bypass && accept) begin
               sreg_d = din;
               srem_d = FullRem;
            end
            if (term) begin
               state_d = StDone;
               done_d  = 1'b1;
               sreg_d  = '0;
               srem_d  = '0;
            end
         end
         default: state_d = StIdle;
      endcase
      en_d = (state_d == StShift) && (srem_d != '0) && (cnt_d < LastCnt);
   end

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state        <= StIdle;
         sreg         <= '0;
         srem         <= '0;
         bit_cnt      <= '0;
         tail_parity  <= 1'b0;
         chain_clk_en <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_d;
         sreg         <= sreg_d;
         srem         <= srem_d;
         bit_cnt      <= cnt_d;
         tail_parity  <= parity_d;
         chain_clk_en <= en_d;
         busy         <= (state_d == StShift);
         done         <= done_d;
      end
   end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: directed loads plus random traffic, checked
// every cycle against a bit-queue model of the chain loader.
module tb_ccff_chain_loader;

   localparam int unsigned W   = 8;
   localparam int unsigned LEN = 20;
   localparam int unsigned CW  = $clog2(LEN + 1);

   logic          prog_clk = 1'b0;
   logic          pReset = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  din = '0;
   logic          din_valid = 1'b0;
   logic          ccff_tail = 1'b0;
   logic          din_ready, ccff_head, chain_clk_en, busy, done, tail_parity;
   logic [CW-1:0] bit_cnt;

   ccff_chain_loader #(
      .WORD_W   (W),
      .CHAIN_LEN(LEN)
   ) dut (
      .prog_clk    (prog_clk),
      .pReset      (pReset),
      .start       (start),
      .din         (din),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .ccff_head   (ccff_head),
      .chain_clk_en(chain_clk_en),
      .ccff_tail   (ccff_tail),
      .busy        (busy),
      .done        (done),
      .bit_cnt     (bit_cnt),
      .tail_parity (tail_parity)
   );

   always #5 prog_clk = ~prog_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: bits accepted but not yet shifted, in shift order.
   bit m_busy, m_done, m_par;
   int m_cnt;
   bit m_buf[$];
   bit head_log[$];
   int en_run, en_run_max;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_par  = 1'b0;
      m_cnt  = 0;
      m_buf.delete();
   endtask

   task automatic check_outputs();
      bit exp_en, exp_rdy;
      exp_en  = m_busy && (m_buf.size() > 0);
      exp_rdy = m_busy && (m_buf.size() <= W);
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
      check("tail_parity", 32'(tail_parity), 32'(m_par));
      check("chain_clk_en", 32'(chain_clk_en), 32'(exp_en));
      check("din_ready", 32'(din_ready), 32'(exp_rdy));
      if (exp_en && chain_clk_en) check("ccff_head", 32'(ccff_head), 32'(m_buf[0]));
      if (chain_clk_en) begin
         head_log.push_back(ccff_head);
         en_run++;
         if (en_run > en_run_max) en_run_max = en_run;
      end else begin
         en_run = 0;
      end
   endtask

   task automatic model_edge(input bit s, input logic [W-1:0] d, input bit v, input bit t);
      bit en, acc;
      en  = m_busy && (m_buf.size() > 0);
      acc = v && m_busy && (m_buf.size() <= W);
      if (!m_busy) begin
         if (s) begin
            model_reset();
            m_busy = 1'b1;
         end
      end else begin
         if (en) begin
            void'(m_buf.pop_front());
            m_cnt++;
            m_par ^= t;
         end
         if (acc) for (int i = 0; i < W; i++) m_buf.push_back(d[i]);
         if (en && m_cnt == LEN) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_buf.delete();
         end
      end
   endtask

   // Entered and left just after a falling edge.
   task automatic tick(input bit s, input logic [W-1:0] d, input bit v, input bit t);
      check_outputs();
      start     = s;
      din       = d;
      din_valid = v;
      ccff_tail = t;
      model_edge(s, d, v, t);
      @(negedge prog_clk);
   endtask

   task automatic send_word(input logic [W-1:0] d);
      bit rdy, sent;
      sent = 1'b0;
      for (int i = 0; i < 40 && !sent; i++) begin
         rdy = m_busy && (m_buf.size() <= W);
         tick(1'b0, d, 1'b1, 1'($urandom_range(0, 1)));
         sent = rdy;
      end
      check("accept_timeout", 32'(sent), 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, W'($urandom), 1'b0, 1'($urandom_range(0, 1)));
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200 && m_busy; i++) tick(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)));
      check("done_timeout", 32'(m_busy), 32'd0);
   endtask

   logic [8:0] basic_exp;

   initial begin
      model_reset();
      en_run     = 0;
      en_run_max = 0;
      repeat (2) @(negedge prog_clk);
      check_outputs();
      check("reset_head", 32'(ccff_head), 32'd0);
      pReset = 1'b0;

      // Basic load: A5 then 01 gives head 1,0,1,0,0,1,0,1,1 first.
      tick(1'b1, '0, 1'b0, 1'b0);
      head_log.delete();
      send_word(8'hA5);
      send_word(8'h01);
      send_word(8'h5A);
      wait_done();
      idle(2);
      basic_exp = 9'h1A5;
      check("basic_len", 32'(head_log.size()), 32'(LEN));
      for (int i = 0; i < 9; i++) check("basic_head", 32'(head_log[i]), 32'(basic_exp[i]));

      // Stall: eight shifts then a bubble with bit_cnt held at 8.
      tick(1'b1, '0, 1'b0, 1'b0);
      send_word(8'h0F);
      idle(13);
      check("stall_cnt", 32'(bit_cnt), 32'd8);
      send_word(8'hF0);
      send_word(8'h33);
      wait_done();

      // Streaming with din_valid held high and a start pulse mid-load.
      tick(1'b1, '0, 1'b0, 1'b0);
      en_run     = 0;
      en_run_max = 0;
      for (int i = 0; i < 30; i++)
         tick(i == 10, W'($urandom), 1'b1, 1'($urandom_range(0, 1)));
      wait_done();
      check("stream_run", 32'(en_run_max), 32'(LEN));

      // Asynchronous reset partway through a load.
      tick(1'b1, '0, 1'b0, 1'b0);
      for (int i = 0; i < 30 && m_cnt < 5; i++)
         tick(1'b0, W'($urandom), 1'b1, 1'($urandom_range(0, 1)));
      check("pre_reset_cnt", 32'(bit_cnt), 32'd5);
      #2 pReset = 1'b1;
      #1 model_reset();
      check_outputs();
      check("async_head", 32'(ccff_head), 32'd0);
      @(negedge prog_clk);
      pReset = 1'b0;

      // Random traffic, including restarts from DONE and ignored starts.
      for (int i = 0; i < 1500; i++) begin
         bit s;
         s = m_busy ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
         tick(s, W'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
      wait_done();
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
